gj_elim_scheduler: RTL
======================

Name: gj_elim_scheduler

Overview:
- Sequences the Gauss-Jordan inversion of the N x 2N augmented matrix held in the single-port DataRam.
- Issues the load, the forward-elimination row ops, the backward-elimination row ops and the write-back, in that order, to the row-op datapath and the RAM load/store unit.
- Each forward or backward row op is the pair (pivot row p, target row t), meaning row t -= (A[t][p]/A[p][p]) * row p.
- Handles start/done sequencing, one-outstanding-op handshakes and zero-pivot abort.

Parameters:
N, 5, matrix order (rows); the augmented width is 2N columns.
IDX_W, 3, row index width; must satisfy 2^IDX_W >= N.
CNT_W, 5, op counter width; must satisfy 2^CNT_W > N*(N-1).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request to begin an inversion; accepted only in IDLE or DONE.
busy  out  1  high from the cycle after an accepted start until DONE is entered.
done  out  1  level; high in DONE, cleared when the next start is accepted.
singular  out  1  valid while done=1; 1 means the run aborted on a zero pivot.
lsu_go  out  1  one-cycle pulse that starts a RAM load or store of the whole matrix.
lsu_dir  out  1  0 = load RAM->matrix, 1 = store matrix->RAM; stable while lsu is in flight.
lsu_done  in  1  one-cycle pulse; the load/store unit finished.
op_valid  out  1  row-op request valid.
op_ready  in  1  datapath accepts the request.
op_pivot  out  IDX_W  pivot row p.
op_target  out  IDX_W  target row t.
op_phase  out  1  0 = forward, 1 = backward.
op_done  in  1  one-cycle pulse; the outstanding op completed.
op_zero  in  1  qualified by op_done; pivot A[p][p] was 0 and the op was not applied.
op_count  out  CNT_W  number of ops completed in the current run.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, p = t = 0, op_count = 0.
- Asserting rst mid-run returns to IDLE immediately. The scheduler drives no further handshakes. Any in-flight lsu_done or op_done is ignored after reset.
- States: IDLE, LOAD, FWD_ISSUE, FWD_WAIT, BWD_ISSUE, BWD_WAIT, STORE, DONE.
- IDLE/DONE on start: clear done, singular and op_count. Set busy. Pulse lsu_go with lsu_dir=0. Go to LOAD.
- start while busy is ignored.
- LOAD on lsu_done: p=0, t=1, go to FWD_ISSUE.
- FWD_ISSUE:
  - op_valid=1, phase=0; indices stay stable until op_valid && op_ready.
  - On that handshake: op_valid drops the next cycle, go to FWD_WAIT.
- FWD_WAIT on op_done:
  - If op_zero: set singular, clear busy, go to DONE. No store is performed; the RAM keeps its original contents.
  - Else: op_count+1, then advance.
    - Forward order: if t < N-1 then t+1; else p+1 and t=p+2 (new p plus one).
    - After (p,t) = (N-2,N-1): p=N-1, t=N-2, go to BWD_ISSUE.
    - Otherwise return to FWD_ISSUE.
- Issue latency: op_valid rises in the cycle immediately after the op_done cycle.
- BWD_ISSUE and BWD_WAIT mirror the forward states with phase=1.
  - Backward order: if t > 0 then t-1; else p-1 and t=p-2 (new p minus one).
  - After (p,t) = (1,0): pulse lsu_go with lsu_dir=1, go to STORE.
- STORE on lsu_done: clear busy, set done, go to DONE.
- Op count for a full run is N(N-1); with N=5, forward = 10, backward = 10, op_count = 20.
- Protocol violations that are ignored:
  - op_done outside a WAIT state.
  - lsu_done outside LOAD/STORE.
  - op_ready while op_valid=0.
- op_done arriving in the same cycle as the handshake is not legal; only one op may be outstanding.
- Counter arithmetic is unsigned with no wrap within a run, guaranteed by the CNT_W constraint.

Decomposition:
- Shared package gj_pkg holds:
  - state enum constants;
  - PHASE_FWD=0 and PHASE_BWD=1;
  - LSU_LOAD=0 and LSU_STORE=1;
  - N_DEFAULT=5.
- One natural sub-module, gj_pair_gen: a pivot/target index generator with inputs init_fwd, init_bwd and step. It outputs p, t and last_fwd/last_bwd flags.
- The FSM and handshakes stay in the top level.

Test Plan:
- Nominal N=5, op_ready tied 1, op_done 2 cycles after each handshake, op_zero=0:
  - ops issued are (0,1),(0,2),(0,3),(0,4),(1,2)…(3,4), then (4,3),(4,2),(4,1),(4,0),(3,2)…(1,0);
  - op_count=20, then one store lsu_go, then done=1 and singular=0.
- Backpressure: op_ready low for 3 cycles on op (1,3) -> op_valid held and indices stable (1,3) for all 3 cycles; exactly one handshake.
- Zero pivot: op_zero=1 on the 5th op (1,2) -> singular=1, done=1, busy=0, no lsu_go with dir=1, op_count=4.
- Reset mid-run: assert rst during BWD_WAIT, then pulse op_done -> all outputs 0, state IDLE; the subsequent start runs a full 20-op sequence.
- start pulsed while busy and in FWD_WAIT -> ignored: no extra lsu_go, sequence unchanged. A new start after done -> done clears the next cycle and op_count resets to 0.
- Spurious op_done in FWD_ISSUE and spurious lsu_done in FWD_WAIT -> no state change and op_count unchanged.

Source files
------------

// File: rtl/gj_pkg.sv
// Shared types and constants for the Gauss-Jordan elimination scheduler.
package gj_pkg;

  localparam int N_DEFAULT = 5;

  localparam logic PHASE_FWD = 1'b0;
  localparam logic PHASE_BWD = 1'b1;

  localparam logic LSU_LOAD  = 1'b0;
  localparam logic LSU_STORE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FWD_ISSUE,
    ST_FWD_WAIT,
    ST_BWD_ISSUE,
    ST_BWD_WAIT,
    ST_STORE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/gj_elim_scheduler_if.sv
// Control/handshake bundle between the scheduler (master) and its environment:
// host start/status, RAM load/store unit and row-op datapath.
interface gj_elim_scheduler_if #(
  parameter int IDX_W = 3,
  parameter int CNT_W = 5
);
  logic             start;
  logic             busy;
  logic             done;
  logic             singular;
  logic             lsu_go;
  logic             lsu_dir;
  logic             lsu_done;
  logic             op_valid;
  logic             op_ready;
  logic [IDX_W-1:0] op_pivot;
  logic [IDX_W-1:0] op_target;
  logic             op_phase;
  logic             op_done;
  logic             op_zero;
  logic [CNT_W-1:0] op_count;

  modport master (
    input  start, lsu_done, op_ready, op_done, op_zero,
    output busy, done, singular, lsu_go, lsu_dir,
           op_valid, op_pivot, op_target, op_phase, op_count
  );

  modport slave (
    output start, lsu_done, op_ready, op_done, op_zero,
    input  busy, done, singular, lsu_go, lsu_dir,
           op_valid, op_pivot, op_target, op_phase, op_count
  );
endinterface

// File: rtl/gj_pair_gen.sv
// Pivot/target row index generator. Direction is latched by the init pulse,
// so step only has to say "advance".
module gj_pair_gen
  import gj_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_fwd,
  input  logic             init_bwd,
  input  logic             step,
  output logic [IDX_W-1:0] p,
  output logic [IDX_W-1:0] t,
  output logic             last_fwd,
  output logic             last_bwd
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  logic [IDX_W-1:0] p_d, p_q, t_d, t_q;
  logic             dir_d, dir_q;

  // Next pair: forward walks t up then bumps p, backward walks t down then drops p.
  always_comb begin
    p_d   = p_q;
    t_d   = t_q;
    dir_d = dir_q;
    if (init_fwd) begin
      p_d   = '0;
      t_d   = IDX_W'(1);
      dir_d = PHASE_FWD;
    end else if (init_bwd) begin
      p_d   = LAST;
      t_d   = IDX_W'(N - 2);
      dir_d = PHASE_BWD;
    end else if (step) begin
      if (dir_q == PHASE_FWD) begin
        if (t_q < LAST) begin
          t_d = t_q + 1'b1;
        end else begin
          p_d = p_q + 1'b1;
          t_d = p_q + IDX_W'(2);
        end
      end else begin
        if (t_q != '0) begin
          t_d = t_q - 1'b1;
        end else begin
          p_d = p_q - 1'b1;
          t_d = p_q - IDX_W'(2);
        end
      end
    end
  end

  // Index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q   <= '0;
      t_q   <= '0;
      dir_q <= PHASE_FWD;
    end else begin
      p_q   <= p_d;
      t_q   <= t_d;
      dir_q <= dir_d;
    end
  end

  assign p        = p_q;
  assign t        = t_q;
  assign last_fwd = (p_q == IDX_W'(N - 2)) && (t_q == LAST);
  assign last_bwd = (p_q == IDX_W'(1)) && (t_q == '0);

endmodule

// File: rtl/gj_elim_scheduler.sv
// Gauss-Jordan inversion sequencer: load, forward ops, backward ops, store.
//
// state        | meaning
// ST_IDLE      | waiting for start after reset
// ST_LOAD      | RAM->matrix load in flight
// ST_FWD_ISSUE | forward row op offered on op_valid
// ST_FWD_WAIT  | forward op accepted, waiting for op_done
// ST_BWD_ISSUE | backward row op offered on op_valid
// ST_BWD_WAIT  | backward op accepted, waiting for op_done
// ST_STORE     | matrix->RAM store in flight
// ST_DONE      | run finished (singular tells why); start re-arms
module gj_elim_scheduler
  import gj_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int IDX_W = 3,
  parameter int CNT_W = 5
) (
  input logic               clk,
  input logic               rst,
  gj_elim_scheduler_if.master bus
);

  state_t           state_d, state_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             singular_d, singular_q;
  logic             lsu_go_d, lsu_go_q;
  logic             lsu_dir_d, lsu_dir_q;
  logic             op_valid_d, op_valid_q;
  logic             phase_d, phase_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             init_fwd, init_bwd, step;
  logic [IDX_W-1:0] pivot, target;
  logic             last_fwd, last_bwd;

  gj_pair_gen #(.N(N), .IDX_W(IDX_W)) u_pair (
    .clk      (clk),
    .rst      (rst),
    .init_fwd (init_fwd),
    .init_bwd (init_bwd),
    .step     (step),
    .p        (pivot),
    .t        (target),
    .last_fwd (last_fwd),
    .last_bwd (last_bwd)
  );

  // Next-state and next-output decode; stray handshakes outside their state fall to defaults.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = done_q;
    singular_d = singular_q;
    lsu_go_d   = 1'b0;
    lsu_dir_d  = lsu_dir_q;
    op_valid_d = op_valid_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    init_fwd   = 1'b0;
    init_bwd   = 1'b0;
    step       = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (bus.start) begin
        done_d     = 1'b0;
        singular_d = 1'b0;
        cnt_d      = '0;
        busy_d     = 1'b1;
        lsu_go_d   = 1'b1;
        lsu_dir_d  = LSU_LOAD;
        state_d    = ST_LOAD;
      end
      ST_LOAD: if (bus.lsu_done) begin
        init_fwd   = 1'b1;
        phase_d    = PHASE_FWD;
        op_valid_d = 1'b1;
        state_d    = ST_FWD_ISSUE;
      end
      ST_FWD_ISSUE, ST_BWD_ISSUE: if (bus.op_ready) begin
        op_valid_d = 1'b0;
        state_d    = (state_q == ST_FWD_ISSUE) ? ST_FWD_WAIT : ST_BWD_WAIT;
      end
      ST_FWD_WAIT, ST_BWD_WAIT: if (bus.op_done) begin
        if (bus.op_zero) begin
          // Abort without storing so the RAM keeps the original matrix.
          singular_d = 1'b1;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (state_q == ST_FWD_WAIT) begin
            op_valid_d = 1'b1;
            if (last_fwd) begin
              init_bwd = 1'b1;
              phase_d  = PHASE_BWD;
              state_d  = ST_BWD_ISSUE;
            end else begin
              step    = 1'b1;
              state_d = ST_FWD_ISSUE;
            end
          end else if (last_bwd) begin
            lsu_go_d  = 1'b1;
            lsu_dir_d = LSU_STORE;
            state_d   = ST_STORE;
          end else begin
            step       = 1'b1;
            op_valid_d = 1'b1;
            state_d    = ST_BWD_ISSUE;
          end
        end
      end
      ST_STORE: if (bus.lsu_done) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      singular_q <= 1'b0;
      lsu_go_q   <= 1'b0;
      lsu_dir_q  <= LSU_LOAD;
      op_valid_q <= 1'b0;
      phase_q    <= PHASE_FWD;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      singular_q <= singular_d;
      lsu_go_q   <= lsu_go_d;
      lsu_dir_q  <= lsu_dir_d;
      op_valid_q <= op_valid_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.singular  = singular_q;
  assign bus.lsu_go    = lsu_go_q;
  assign bus.lsu_dir   = lsu_dir_q;
  assign bus.op_valid  = op_valid_q;
  assign bus.op_pivot  = pivot;
  assign bus.op_target = target;
  assign bus.op_phase  = phase_q;
  assign bus.op_count  = cnt_q;

endmodule
